// File: rtl/wb_vmon_txn_capture.sv
// Passive Wishbone transaction recorder: snoops completed transfers, filters them by
// address window, timestamps them and queues them in a first-word-fall-through FIFO.
module wb_vmon_txn_capture #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_WIDTH   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   ADR,
    input  logic [DATA_WIDTH-1:0]   DAT_W,
    input  logic [DATA_WIDTH-1:0]   DAT_R,
    input  logic                    CYC,
    input  logic                    STB,
    input  logic [DATA_WIDTH/8-1:0] SEL,
    input  logic                    WE,
    input  logic                    ACK,
    input  logic                    ERR,
    input  logic                    en_i,
    input  logic [ADDR_WIDTH-1:0]   filt_base_i,
    input  logic [ADDR_WIDTH-1:0]   filt_mask_i,
    input  logic                    clr_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [TS_WIDTH-1:0]     out_ts_o,
    output logic [ADDR_WIDTH-1:0]   out_adr_o,
    output logic [DATA_WIDTH-1:0]   out_dat_o,
    output logic [DATA_WIDTH/8-1:0] out_sel_o,
    output logic                    out_we_o,
    output logic                    out_err_o,
    output logic [DEPTH_LOG2:0]     count_o,
    output logic                    overflow_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int REC_W = TS_WIDTH + ADDR_WIDTH + DATA_WIDTH + SEL_W + 2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [TS_WIDTH-1:0]   ts_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic                  overflow_q;
    logic [15:0]           drop_cnt_q;
    logic [REC_W-1:0]      mem [DEPTH];

    logic term, hit, full, valid, push, pop, drop;
    logic [REC_W-1:0] rec;

    assign term  = CYC & STB & (ACK | ERR);
    assign hit   = term & en_i & ((ADR & filt_mask_i) == (filt_base_i & filt_mask_i));
    assign full  = (count_q == FULL_CNT);
    assign valid = (count_q != '0);
    assign pop   = valid & out_ready_i;
    // A pop frees the slot at the edge it is written, so a full FIFO still accepts a hit.
    assign push  = hit & (~full | pop);
    assign drop  = hit & full & ~pop;
    assign rec   = {ts_q, ADR, (WE ? DAT_W : DAT_R), SEL, WE, ERR};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ts_q       <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (clr_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= rec;
    end

    logic [TS_WIDTH-1:0]   h_ts;
    logic [ADDR_WIDTH-1:0] h_adr;
    logic [DATA_WIDTH-1:0] h_dat;
    logic [SEL_W-1:0]      h_sel;
    logic                  h_we, h_err;

    assign {h_ts, h_adr, h_dat, h_sel, h_we, h_err} = mem[rd_ptr_q];

    assign out_valid_o = valid;
    assign out_ts_o    = valid ? h_ts  : '0;
    assign out_adr_o   = valid ? h_adr : '0;
    assign out_dat_o   = valid ? h_dat : '0;
    assign out_sel_o   = valid ? h_sel : '0;
    assign out_we_o    = valid & h_we;
    assign out_err_o   = valid & h_err;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/wb_vmon_txn_capture.md
Name: wb_vmon_txn_capture

Overview:
- Passive Wishbone transaction recorder, downstream of the Wishbone bus monitor on the peripheral-interconnect master-0 port.
- Snoops the same bus signals and detects each completed transfer (CYC & STB & (ACK | ERR)).
- Filters completed transfers by address window, timestamps them and buffers them in a FIFO.
- A testbench-side consumer drains the FIFO through a valid/ready port. Never drives the bus.

Parameters:
- ADDR_WIDTH, 32, width of ADR.
- DATA_WIDTH, 32, width of DAT_W/DAT_R; SEL width is DATA_WIDTH/8.
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 records (16).
- TS_WIDTH, 32, timestamp counter width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset; asynchronous, active-low.
- ADR  in  ADDR_WIDTH  bus address.
- DAT_W  in  DATA_WIDTH  write data.
- DAT_R  in  DATA_WIDTH  read data.
- CYC  in  1  bus cycle.
- STB  in  1  strobe.
- SEL  in  DATA_WIDTH/8  byte selects.
- WE  in  1  write enable.
- ACK  in  1  slave acknowledge.
- ERR  in  1  slave error.
- en_i  in  1  capture enable.
- filt_base_i  in  ADDR_WIDTH  filter base.
- filt_mask_i  in  ADDR_WIDTH  filter mask; 0 = match all.
- clr_i  in  1  synchronous clear of overflow flag and drop counter.
- out_valid_o  out  1  record available.
- out_ready_i  in  1  consumer accepts record.
- out_ts_o  out  TS_WIDTH  timestamp of completion.
- out_adr_o  out  ADDR_WIDTH  captured address.
- out_dat_o  out  DATA_WIDTH  DAT_W if write, DAT_R if read.
- out_sel_o  out  DATA_WIDTH/8  captured SEL.
- out_we_o  out  1  captured WE.
- out_err_o  out  1  1 = ERR terminated the transfer.
- count_o  out  DEPTH_LOG2+1  FIFO occupancy.
- overflow_o  out  1  sticky; a hit was dropped.
- drop_cnt_o  out  16  dropped-hit count, saturates at 16'hFFFF.

Behaviour:
- Reset (rst_i low, async): FIFO empty, count_o=0, out_valid_o=0, all out_* data=0, ts counter=0, overflow_o=0, drop_cnt_o=0. Reset mid-transfer discards all records; no partial push.
- Timestamp: free-running TS_WIDTH counter, +1 every clk after reset release, wraps 2^TS_WIDTH-1 -> 0. A record takes the counter value in the completion cycle.
- Completion: term = CYC & STB & (ACK | ERR), sampled at posedge. Each cycle with term=1 is one transfer, so back-to-back acks give one record per cycle.
  - If ACK and ERR are both high, record err=1.
  - STB without CYC, or ACK without STB, is ignored.
- hit = term & en_i & ((ADR & filt_mask_i) == (filt_base_i & filt_mask_i)).
- Push: hit and (count < DEPTH, or pop in the same cycle). Record = {ts, ADR, WE ? DAT_W : DAT_R, SEL, WE, err}.
- Drop: hit and full and no pop that cycle.
  - overflow_o set to 1 next cycle.
  - drop_cnt_o increments, saturating.
  - The drop does not disturb stored records.
- Pop: out_valid_o & out_ready_i; head advances next cycle.
- Output: first-word-fall-through with registered status. A push into an empty FIFO gives out_valid_o=1 in the following cycle, so capture-to-output latency is 1 clk. out_* are stable while out_valid_o=1 and not popped.
- Simultaneous push+pop: count unchanged. When empty, the push is not bypassed in that cycle; it appears next cycle.
- Pointers: DEPTH_LOG2 bits each, wrap modulo DEPTH. Full/empty come from count.
- clr_i: overflow_o<=0, drop_cnt_o<=0 next cycle. If a drop happens in the same cycle as clr_i, clr_i wins and results in 0.
- en_i low: no new hits. Stored records remain poppable.
- Pure observer: no outputs toward the bus.

Test Plan:
1. Reset, en_i=1, mask=0. Write ADR=0x1000_0004, DAT_W=0xDEAD_BEEF, SEL=4'hF, ACK in cycle N -> out_valid_o=1 at N+1; adr=0x1000_0004, dat=0xDEAD_BEEF, we=1, err=0; ts = cycles since reset release at N.
2. Read ADR=0x1000_0008, DAT_R=0x0000_00A5 completed with ERR=1 -> record dat=0x0000_00A5, we=0, err=1. A cycle with ACK=1, STB=0 -> no record.
3. filt_base=0x1000_0000, filt_mask=0xFFFF_0000. Accesses to 0x1000_0010 and 0x2000_0010 -> exactly one record (0x1000_0010).
4. out_ready_i=0, 18 back-to-back acked writes -> count_o=16, overflow_o=1, drop_cnt_o=2. Pulse clr_i -> both 0. Then 16 pops return the first 16 writes in order.
5. FIFO holding 16 records: pop and hit in the same cycle -> count stays 16, no drop, new record is last. Continuous ready with one ack per cycle -> steady count_o=1, no loss.
6. Assert rst_i low asynchronously while holding 5 records -> out_valid_o, count_o and ts drop to 0 immediately, without waiting for a clock edge.
